// File: rtl/c_rr_decr_arb_pkg.sv
// Shared constants for the decrementing round-robin arbiter:
// arbiter state encoding and the index-width helper.
package c_rr_decr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // Hold counter width; covers hold_max up to 255.
  localparam int unsigned hcnt_width = 8;

  // Number of bits needed to index n items (minimum 1).
  function automatic int unsigned clogb(input int unsigned n);
    int unsigned w;
    int unsigned v;
    w = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      w++;
      v = v >> 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/c_rr_decr_arb_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface c_rr_decr_arb_if
  import c_rr_decr_arb_pkg::*;
#(
  parameter int unsigned num_ports = 4
);

  logic [0:num_ports-1]        req;
  logic [0:num_ports-1]        grant;
  logic                        grant_valid;
  logic [0:clogb(num_ports)-1] grant_idx;

  modport master (
    output req,
    input  grant,
    input  grant_valid,
    input  grant_idx
  );

  modport slave (
    input  req,
    output grant,
    output grant_valid,
    output grant_idx
  );

endinterface

// File: rtl/c_rr_decr_arb_decr.sv
// Wrapping decrementer: min_value steps to max_value, everything else
// steps down by one.
module c_decr #(
  parameter int unsigned width     = 2,
  parameter int unsigned min_value = 0,
  parameter int unsigned max_value = 3
) (
  input  logic [0:width-1] data_in,
  output logic [0:width-1] data_out
);

  // Wrap at the lower bound, otherwise subtract one.
  always_comb begin
    if (data_in == width'(min_value)) begin
      data_out = width'(max_value);
    end else begin
      data_out = data_in - width'(1);
    end
  end

endmodule

// File: rtl/c_rr_decr_arb.sv
// Round-robin arbiter with a downward-searching priority pointer and a
// bounded grant hold time. A releasing port drops to lowest priority.
module c_rr_decr_arb
  import c_rr_decr_arb_pkg::*;
#(
  parameter int unsigned num_ports = 4,
  parameter int unsigned hold_max  = 3
) (
  input  logic            clk,
  input  logic            reset,
  c_rr_decr_arb_if.slave  bus
);

  localparam int unsigned idx_w = clogb(num_ports);

  arb_state_t               state_q, state_d;
  logic [0:idx_w-1]         ptr, ptr_d;
  logic [0:idx_w-1]         ptr_rel;
  logic [hcnt_width-1:0]    hcnt, hcnt_d;
  logic [0:num_ports-1]     grant_q, grant_d;
  logic                     valid_q, valid_d;
  logic [0:idx_w-1]         idx_q, idx_d;

  logic                     release_c;
  logic [0:idx_w-1]         search_base;
  logic                     win_found;
  logic [0:idx_w-1]         win_idx;
  int unsigned              cand;

  // Pointer value that puts the current holder at lowest priority.
  c_decr #(
    .width     (idx_w),
    .min_value (0),
    .max_value (num_ports - 1)
  ) ptr_decr (
    .data_in  (idx_q),
    .data_out (ptr_rel)
  );

  // Release detection and the pointer the search starts from this cycle.
  always_comb begin
    release_c   = (state_q == BUSY) && (!bus.req[idx_q] || (hcnt == '0));
    search_base = release_c ? ptr_rel : ptr;
  end

  // First requester found walking down from search_base, wrapping to the top.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < num_ports; k++) begin
      if (int'(search_base) >= int'(k)) begin
        cand = int'(search_base) - k;
      end else begin
        cand = int'(search_base) + num_ports - k;
      end
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = idx_w'(cand);
      end
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY controller.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr;
    hcnt_d  = hcnt;
    grant_d = grant_q;
    valid_d = valid_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = BUSY;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          valid_d          = 1'b1;
          idx_d            = win_idx;
          hcnt_d           = hcnt_width'(hold_max - 1);
        end
      end
      BUSY: begin
        if (!release_c) begin
          hcnt_d = (hcnt == '0) ? '0 : hcnt - 1'b1;
        end else begin
          ptr_d = ptr_rel;
          if (win_found) begin
            grant_d          = '0;
            grant_d[win_idx] = 1'b1;
            valid_d          = 1'b1;
            idx_d            = win_idx;
            hcnt_d           = hcnt_width'(hold_max - 1);
          end else begin
            state_d = IDLE;
            grant_d = '0;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr     <= idx_w'(num_ports - 1);
      hcnt    <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr     <= ptr_d;
      hcnt    <= hcnt_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      idx_q   <= idx_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.grant_valid = valid_q;
  assign bus.grant_idx   = idx_q;

endmodule

// File: tb/tb_c_rr_decr_arb.sv
// Bench for c_rr_decr_arb: directed scenarios with literal expectations
// plus a randomized run compared every cycle against a behavioural model.
module tb_c_rr_decr_arb;
  import c_rr_decr_arb_pkg::*;

  localparam int N    = 4;
  localparam int HOLD = 3;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  c_rr_decr_arb_if #(.num_ports(N)) bus ();

  c_rr_decr_arb #(
    .num_ports (N),
    .hold_max  (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Behavioural model: who holds the grant, for how many cycles so far,
  // and which port currently has top priority.
  int m_holder = -1;
  int m_held   = 0;
  int m_ptr    = N - 1;
  int m_idx    = 0;
  int waitc[N];
  logic [0:N-1] req_s;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_holder = -1;
    m_held   = 0;
    m_ptr    = N - 1;
    m_idx    = 0;
    for (int p = 0; p < N; p++) waitc[p] = 0;
  endtask

  task automatic m_step(input logic [0:N-1] r);
    bit pick;
    pick = 1'b0;
    if (m_holder < 0) begin
      pick = (r != '0);
    end else if (!r[m_holder] || m_held == HOLD) begin
      m_ptr = (m_holder + N - 1) % N;
      if (r != '0) pick = 1'b1;
      else m_holder = -1;
    end else begin
      m_held++;
    end
    if (pick) begin
      for (int k = 0; k < N; k++) begin
        int c;
        c = (m_ptr - k + N) % N;
        if (r[c]) begin
          m_holder = c;
          m_idx    = c;
          m_held   = 1;
          break;
        end
      end
    end
  endtask

  // Model update and DUT comparison, 1 time unit after each edge/reset.
  initial begin : compare_proc
    logic [0:N-1] eg;
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
        m_reset();
      end else begin
        req_s = bus.req;
        m_step(req_s);
      end
      #1;
      eg = '0;
      if (m_holder >= 0) eg[m_holder] = 1'b1;
      check("grant", 32'(bus.grant), 32'(eg));
      check("grant_valid", 32'(bus.grant_valid), 32'(m_holder >= 0));
      check("grant_idx", 32'(bus.grant_idx), 32'(m_idx));
      check("ptr", 32'(dut.ptr), 32'(m_ptr));
      if (reset) begin
        check("onehot", 32'($countones(bus.grant) <= 1), 32'd1);
        for (int p = 0; p < N; p++) begin
          if (req_s[p] && !bus.grant[p]) waitc[p]++;
          else waitc[p] = 0;
          check("starve", 32'(waitc[p] <= 9), 32'd1);
        end
      end
    end
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic set_req(input bit b0, input bit b1, input bit b2, input bit b3);
    bus.req[0] = b0;
    bus.req[1] = b1;
    bus.req[2] = b2;
    bus.req[3] = b3;
  endtask

  // Hold reset for two cycles; returns at the negedge where reset rises (cycle 0).
  task automatic do_reset();
    @(negedge clk);
    reset   = 1'b0;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin : stim
    int seq[13];
    seq = '{3, 3, 3, 2, 2, 2, 1, 1, 1, 0, 0, 0, 3};
    bus.req = '0;

    // Reset state and first grant, then early drop by the holder.
    do_reset();
    check("rst_valid", 32'(bus.grant_valid), 32'd0);
    check("rst_ptr", 32'(dut.ptr), 32'd3);
    set_req(0, 1, 1, 0);
    cyc();
    check("s1_idx", 32'(bus.grant_idx), 32'd2);
    check("s1_valid", 32'(bus.grant_valid), 32'd1);
    set_req(0, 0, 1, 0);
    cyc();
    check("s4_hold2", 32'(bus.grant[2]), 32'd1);
    set_req(0, 0, 0, 1);
    cyc();
    check("s4_next_idx", 32'(bus.grant_idx), 32'd3);
    check("s4_next_valid", 32'(bus.grant_valid), 32'd1);
    check("s4_g2_off", 32'(bus.grant[2]), 32'd0);

    // Rotation with every port requesting.
    do_reset();
    set_req(1, 1, 1, 1);
    for (int i = 0; i < 13; i++) begin
      cyc();
      check("s2_idx", 32'(bus.grant_idx), 32'(seq[i]));
      check("s2_valid", 32'(bus.grant_valid), 32'd1);
    end

    // Sole requester is regranted back-to-back.
    do_reset();
    set_req(1, 0, 0, 0);
    for (int i = 1; i <= 10; i++) begin
      cyc();
      check("s3_g0", 32'(bus.grant[0]), 32'd1);
      if (i == 4 || i == 7) check("s3_ptr", 32'(dut.ptr), 32'd3);
    end

    // Reset in the middle of a grant.
    do_reset();
    set_req(0, 1, 0, 0);
    cyc();
    cyc();
    check("s5_pre_g1", 32'(bus.grant[1]), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("s5_grant", 32'(bus.grant), 32'd0);
    check("s5_valid", 32'(bus.grant_valid), 32'd0);
    check("s5_idx", 32'(bus.grant_idx), 32'd0);
    check("s5_ptr", 32'(dut.ptr), 32'd3);
    cyc();
    cyc();
    reset = 1'b1;
    set_req(1, 0, 0, 1);
    cyc();
    check("s5_after_idx", 32'(bus.grant_idx), 32'd3);

    // Randomized run with sticky requests so holds and starvation bounds get exercised.
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(3) == 0) bus.req[p] = ~bus.req[p];
      end
      cyc();
    end
    bus.req = '0;
    cyc();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c_rr_decr_arb.md
C_RR_DECR_ARB -- requirements
Module: c_rr_decr_arb

Interface
REQ-001 Parameter num_ports, default 4, number of requesters sharing one resource; range 2..16.
REQ-002 Parameter hold_max, default 3, maximum consecutive cycles one grant is held; range 1..255.
REQ-003 Port clk  input  1  sole clock; all state changes on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port req  input  [0:num_ports-1]  request vector; bit i is port i; level-sensitive.
REQ-006 Port grant  output  [0:num_ports-1]  registered grant vector; zero or one-hot.
REQ-007 Port grant_valid  output  1  registered; high exactly when grant is non-zero.
REQ-008 Port grant_idx  output  [0:clogb(num_ports)-1]  registered index of the granted port; holds its last value while grant_valid is low.

Function
REQ-009 Two states: IDLE (no grant) and BUSY (one grant outstanding).
REQ-010 Priority pointer ptr, range 0..num_ports-1.
REQ-011 Search order is ptr, ptr-1, ..., 0, then wrap to num_ports-1, continuing down to ptr+1.
REQ-012 Wrap decrement rule: 0 decremented gives num_ports-1; all other values decrement by 1.
REQ-013 IDLE, any req bit high: winner is the first set bit in search order; state becomes BUSY; grant is set one-hot at the next edge (latency 1 cycle).
REQ-014 The hold counter hcnt is loaded with hold_max-1 when a grant is issued.
REQ-015 IDLE, req all zero: IDLE is retained and outputs are unchanged.
REQ-016 BUSY release condition: req[grant_idx] is low, or hcnt equals 0.
REQ-017 BUSY, no release: hcnt decrements by 1 per cycle and the grant is unchanged.
REQ-018 On release, ptr becomes grant_idx wrap-decremented, so the releasing port drops to lowest priority.
REQ-019 On release with any req set, a new winner is selected with the updated ptr and granted at the next edge with no idle cycle; state remains BUSY.
REQ-020 On release with req all zero: state becomes IDLE, and grant and grant_valid clear at the next edge.
REQ-021 A port whose hold expired and which still requests competes again at lowest priority; if it is the sole requester, it is regranted back-to-back.
REQ-022 Because grant is registered, it stays high for one cycle after the holder deasserts req.
REQ-023 Requests from other ports never pre-empt a grant before the release condition.
REQ-024 A single grant lasts at most hold_max consecutive cycles.
REQ-025 Asserting req on a port that is not granted has no effect while BUSY until release.

Reset
REQ-026 While reset is low, all outputs update immediately, independent of clk: grant=0, grant_valid=0, grant_idx=0, state=IDLE, ptr=num_ports-1, hcnt=0.
REQ-027 Reset asserted mid-grant aborts the grant immediately, and no state from before reset survives.
REQ-028 Arbitration can first occur at the first rising edge after reset deasserts.

Structure
REQ-029 State encodings (IDLE/BUSY) and the clogb function belong in the shared constants package.
REQ-030 The pointer update instantiates c_decr with min_value=0 and max_value=num_ports-1.
REQ-031 The hold counter uses plain saturating-at-zero logic, not c_decr.
REQ-032 The winner search is combinational logic in this module.

Verification
REQ-033 Bench parameters: num_ports=4, hold_max=3.
REQ-034 Scenario 1, first grant: after reset, req[1] and req[2] high from cycle 0 -> grant_idx=2 at cycle 1.
REQ-035 Scenario 2, rotation: all four req held high -> grant_idx sequence 3,3,3,2,2,2,1,1,1,0,0,0,3, with no gaps.
REQ-036 Scenario 3, sole requester: req[0] alone held high for 10 cycles -> grant[0] high continuously from cycle 1; ptr reads 3 after the first release.
REQ-037 Scenario 4, early drop: port 2 granted, req[2] drops one cycle later, req[3] high -> grant[2] is high for 2 cycles, then grant_idx=3 with no idle cycle.
REQ-038 Scenario 5, reset mid-grant: reset low during a grant -> grant=0 and grant_valid=0 before the next edge; after reset, req[0] and req[3] high -> grant_idx=3.
REQ-039 Scenario 6, invariants: random req for 10k cycles -> grant is always zero or one-hot, no grant exceeds 3 cycles, and every continuously requesting port is granted within 9 cycles.
